opentdc_wb_host: RTL and testbench

//  Wishbone classic single-transfer initiator: turns a valid/ready command stream into one
//  bus cycle on a WB slave such as opentdc_wb, and returns read data/status on a response stream.

---
 rtl/opentdc_wb_host.sv | 125 ++++++++++++
 tb/tb_opentdc_wb_host.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/opentdc_wb_host.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle out, one response back.
// A cycle counter aborts bus cycles that are never acknowledged.
module opentdc_wb_host #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            wb_clk_i,
  input  logic            rst_n_i,
  // command stream
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  // response stream
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  // wishbone master
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic            cyc_reg;
  logic            we_reg;
  logic [SW-1:0]   sel_reg;
  logic [AW-1:0]   adr_reg;
  logic [DW-1:0]   dat_reg;
  logic            rsp_valid_reg;
  logic [DW-1:0]   rsp_dat_reg;
  logic            rsp_err_reg;

  // Ready is decoded from state so it is already high while reset is held.
  assign cmd_ready_o = (state_reg == IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            we_reg    <= cmd_we_i;
            adr_reg   <= cmd_adr_i;
            dat_reg   <= cmd_dat_i;
            sel_reg   <= cmd_sel_i;
            cyc_reg   <= 1'b1;
            timer_reg <= '0;
            state_reg <= BUS;
          end
        end
        BUS: begin
          // An ack arriving on the final allowed cycle still completes normally.
          if (wbm_ack_i) begin
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= we_reg ? '0 : wbm_dat_i;
            rsp_err_reg   <= 1'b0;
            state_reg     <= RESP;
          end else if (timer_reg == TIMER_LAST) begin
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b1;
            state_reg     <= RESP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          cyc_reg       <= 1'b0;
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = cyc_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_dat_o   = rsp_dat_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_opentdc_wb_host.sv
// Bench for opentdc_wb_host: register-file slave with scripted ack delay and a
// transaction-level reference model of expected bus length and response.
module tb_opentdc_wb_host;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 64;
  localparam int NEVER = TO + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [SW-1:0] wbm_sel;
  logic [AW-1:0] wbm_adr;
  logic [DW-1:0] wbm_dat_out, wbm_dat_in;

  always #5 clk = ~clk;

  opentdc_wb_host #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i    (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_out),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dat_in)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] slave_mem [16];
  logic [DW-1:0] ref_mem   [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Runs one command from IDLE (called at a negedge) through the response handshake.
  task automatic do_txn(input logic we, input logic [3:0] idx, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel, input int ack_at, input int rsp_delay,
                        input bit spurious);
    logic [AW-1:0] adr;
    int            exp_cyc, cycles;
    logic          exp_err;
    logic [DW-1:0] exp_dat;
    logic [3:0]    sidx;
    adr     = {26'h0, idx, 2'b00};
    exp_err = (ack_at > TO);
    exp_cyc = exp_err ? TO : ack_at;
    exp_dat = (!we && !exp_err) ? ref_mem[idx] : '0;
    if (we && !exp_err) ref_mem[idx] = merge(ref_mem[idx], dat, sel);

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    cycles = 0;
    while (wbm_cyc && cycles < TO + 4) begin
      cycles++;
      check("stb_eq_cyc", wbm_stb, 1);
      check("bus_we", wbm_we, we);
      check("bus_adr", wbm_adr, adr);
      check("bus_dat", wbm_dat_out, dat);
      check("bus_sel", wbm_sel, sel);
      check("bus_cmd_ready", cmd_ready, 0);
      check("bus_rsp_valid", rsp_valid, 0);
      if (cycles == ack_at) begin
        wbm_ack = 1'b1;
        sidx = wbm_adr[5:2];
        if (wbm_we) slave_mem[sidx] = merge(slave_mem[sidx], wbm_dat_out, wbm_sel);
        else        wbm_dat_in = slave_mem[sidx];
      end else begin
        wbm_ack    = 1'b0;
        wbm_dat_in = $urandom;
      end
      @(negedge clk);
    end
    wbm_ack = 1'b0;
    check("cyc_cycles", cycles, exp_cyc);
    check("stb_low", wbm_stb, 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", rsp_err, exp_err);
    for (int i = 0; i < rsp_delay; i++) begin
      if (spurious) begin
        cmd_valid  = 1'b1;
        wbm_ack    = (i % 3 == 0);
        wbm_dat_in = $urandom;
      end
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_dat", rsp_dat, exp_dat);
      check("hold_rsp_err", rsp_err, exp_err);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_cyc", wbm_cyc, 0);
    end
    cmd_valid = 1'b0; wbm_ack = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_cyc", wbm_cyc, 0);
    $display("[TB] txn we=%0b adr=%08h dat=%08h sel=%h ack_at=%0d cyc=%0d rsp_dat=%08h err=%0b",
             we, adr, dat, sel, ack_at, cycles, exp_dat, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack = 1'b0; wbm_dat_in = '0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end
    repeat (2) @(negedge clk);
    check("rst_cyc", wbm_cyc, 0);
    check("rst_stb", wbm_stb, 0);
    check("rst_we", wbm_we, 0);
    check("rst_adr", wbm_adr, 0);
    check("rst_dat", wbm_dat_out, 0);
    check("rst_sel", wbm_sel, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write acked on 2nd cycle, read acked on 1st, timeout, ack on last cycle.
    do_txn(1'b1, 4'd1, 32'hDEAD_BEEF, 4'hF, 2, 0, 1'b0);
    slave_mem[4] = 32'h1234_5678;
    ref_mem[4]   = 32'h1234_5678;
    do_txn(1'b0, 4'd4, '0, 4'hF, 1, 0, 1'b0);
    do_txn(1'b0, 4'd4, '0, 4'hF, NEVER, 1, 1'b0);
    do_txn(1'b0, 4'd4, '0, 4'hF, TO, 1, 1'b0);
    // Backpressure with spurious acks and offered commands while responding.
    do_txn(1'b0, 4'd1, '0, 4'hF, 3, 10, 1'b1);

    // Spurious ack while idle.
    wbm_ack = 1'b1; wbm_dat_in = $urandom;
    @(negedge clk);
    wbm_ack = 1'b0;
    check("idle_ack_cyc", wbm_cyc, 0);
    check("idle_ack_rsp", rsp_valid, 0);
    check("idle_ack_ready", cmd_ready, 1);

    // Reset during the third bus cycle of a never-acked read.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h8; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_cyc", wbm_cyc, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cyc", wbm_cyc, 0);
    check("mid_rst_stb", wbm_stb, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rsp", rsp_valid, 0);
    do_txn(1'b1, 4'd2, 32'hCAFE_F00D, 4'hF, 1, 0, 1'b0);

    // Back-to-back alternating write/read pairs.
    for (int k = 0; k < 2; k++) begin
      logic [3:0] idx;
      idx = 4'($urandom);
      do_txn(1'b1, idx, $urandom, 4'hF, 1, 0, 1'b0);
      do_txn(1'b0, idx, '0, 4'hF, 1, 0, 1'b0);
    end

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      int r, ack_at;
      r = $urandom_range(0, 9);
      if (r == 0)      ack_at = NEVER;
      else if (r == 1) ack_at = TO;
      else             ack_at = $urandom_range(1, 6);
      do_txn(1'($urandom), 4'($urandom), $urandom, 4'($urandom), ack_at,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
